// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between an instruction-fetch
// requester (I) and a load/store requester (D). One transaction in flight at
// a time; D has priority, but I is guaranteed a grant after MAX_D_STREAK
// consecutive D grants that it sat through.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int WIDTH        = 32
) (
    input  logic             clk,
    input  logic             reset,
    // instruction port
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic             i_ack,
    output logic [WIDTH-1:0] i_rdata,
    // data port
    input  logic             d_req,
    input  logic [3:0]       d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_ack,
    output logic [WIDTH-1:0] d_rdata,
    // backing memory
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_rw,
    output logic [3:0]       mem_wmask,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_resp_valid,
    input  logic [WIDTH-1:0] mem_resp_data,
    // pipeline hold
    output logic             stall
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state_q,     state_d;
    logic             owner_d_q,   owner_d_d;   // 1 = D port owns the transaction
    logic             mem_rw_q,    mem_rw_d;
    logic [3:0]       mem_wmask_q, mem_wmask_d;
    logic [WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0] i_rdata_q,   i_rdata_d;
    logic [WIDTH-1:0] d_rdata_q,   d_rdata_d;
    logic [3:0]       d_streak_q,  d_streak_d;

    logic streak_full;
    logic grant_d;
    logic grant_i;

    // Byte-offset bits never reach memory; requests are always word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // Arbitration: D wins unless I has waited out a full D streak.
    always_comb begin
        streak_full = (d_streak_q == 4'(MAX_D_STREAK));
        grant_d     = d_req & ~(i_req & streak_full);
        grant_i     = i_req & ~grant_d;
    end

    // Next-state and registered-field update for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        mem_rw_d    = mem_rw_q;
        mem_wmask_d = mem_wmask_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        d_streak_d  = d_streak_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    owner_d_d   = 1'b1;
                    mem_addr_d  = {d_addr[WIDTH-1:2], 2'b00};
                    mem_wdata_d = d_wdata;
                    mem_wmask_d = d_we;
                    mem_rw_d    = |d_we;
                    // Count only grants that made I wait; saturate at the limit.
                    if (!i_req)
                        d_streak_d = 4'd0;
                    else if (!streak_full)
                        d_streak_d = d_streak_q + 4'd1;
                    state_d = ISSUE;
                end else if (grant_i) begin
                    owner_d_d   = 1'b0;
                    mem_addr_d  = {i_addr[WIDTH-1:2], 2'b00};
                    mem_wdata_d = '0;
                    mem_wmask_d = 4'b0000;
                    mem_rw_d    = 1'b0;
                    d_streak_d  = 4'd0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    // Write responses carry no useful data; d_rdata keeps its value.
                    if (!owner_d_q)
                        i_rdata_d = mem_resp_data;
                    else if (!mem_rw_q)
                        d_rdata_d = mem_resp_data;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and field registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_wmask_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            d_streak_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            mem_rw_q    <= mem_rw_d;
            mem_wmask_q <= mem_wmask_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            d_streak_q  <= d_streak_d;
        end
    end

    // Outputs decoded from state; stall tracks outstanding requests directly.
    always_comb begin
        mem_req_valid = (state_q == ISSUE);
        i_ack         = (state_q == DONE) & ~owner_d_q;
        d_ack         = (state_q == DONE) &  owner_d_q;
        mem_rw        = mem_rw_q;
        mem_wmask     = mem_wmask_q;
        mem_addr      = mem_addr_q;
        mem_wdata     = mem_wdata_q;
        i_rdata       = i_rdata_q;
        d_rdata       = d_rdata_q;
        stall         = (i_req & ~i_ack) | (d_req & ~d_ack);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized
// request traffic against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int W    = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, mem_req_ready, mem_resp_valid;
    logic [W-1:0]  i_addr, d_addr, d_wdata, mem_resp_data;
    logic [3:0]    d_we;
    logic          i_ack, d_ack, mem_req_valid, mem_rw, stall;
    logic [W-1:0]  i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]    mem_wmask;

    mem_arbiter #(.MAX_D_STREAK(MAXS), .WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_rw(mem_rw), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state: pending requests, arbitration history, expected read data
    logic         pi, pd;
    logic [W-1:0] ia, da, dw;
    logic [3:0]   dwe;
    int           streak;
    logic [W-1:0] exp_ir, exp_dr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        i_req = pi; i_addr = ia;
        d_req = pd; d_addr = da; d_we = dwe; d_wdata = dw;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_i_ack"}, i_ack, 0);
        chk({tag, "_d_ack"}, d_ack, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_rw"}, mem_rw, 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pi = 0; pd = 0; ia = '0; da = '0; dw = '0; dwe = '0;
        drive();
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        streak = 0; exp_ir = '0; exp_dr = '0;
        tick(); tick();
        chk_zero_outputs("reset");
        chk("reset_stall", stall, 0);
        reset = 1'b0;
        tick();
    endtask

    // One full transaction from the IDLE cycle; returns which port was acked.
    task automatic do_txn(input int rdy_dly, input int rsp_dly, input logic [W-1:0] rdat,
                          output logic got_d);
        logic         own_d, e_rw;
        logic [W-1:0] e_addr, e_wdata;
        logic [3:0]   e_mask;
        own_d = pd && !(pi && streak == MAXS);
        if (own_d) begin
            e_addr = {da[W-1:2], 2'b00}; e_wdata = dw; e_mask = dwe; e_rw = (dwe != 0);
            streak = pi ? ((streak < MAXS) ? streak + 1 : streak) : 0;
        end else begin
            e_addr = {ia[W-1:2], 2'b00}; e_wdata = '0; e_mask = 0; e_rw = 0;
            streak = 0;
        end
        drive();
        tick();
        for (int k = 0; k <= rdy_dly; k++) begin
            chk("issue_valid", mem_req_valid, 1);
            chk("issue_addr", mem_addr, e_addr);
            chk("issue_rw", mem_rw, e_rw);
            chk("issue_wmask", mem_wmask, e_mask);
            if (e_rw) chk("issue_wdata", mem_wdata, e_wdata);
            chk("issue_stall", stall, 1);
            if (k == rdy_dly) begin
                drive();
                mem_resp_valid = 0;
                mem_req_ready = 1;
            end else begin
                // request fields may wander while not sampled
                i_addr = $urandom; d_addr = $urandom; d_we = 4'($urandom);
                mem_resp_valid = 1'($urandom);
            end
            tick();
        end
        mem_req_ready = 0;
        for (int k = 0; k < rsp_dly; k++) begin
            chk("wait_valid", mem_req_valid, 0);
            chk("wait_ack", {i_ack, d_ack}, 0);
            tick();
        end
        mem_resp_valid = 1; mem_resp_data = rdat;
        tick();
        mem_resp_valid = 0; mem_resp_data = $urandom;
        if (!own_d) exp_ir = rdat;
        else if (!e_rw) exp_dr = rdat;
        got_d = d_ack;
        chk("done_i_ack", i_ack, !own_d);
        chk("done_d_ack", d_ack, own_d);
        chk("done_i_rdata", i_rdata, exp_ir);
        chk("done_d_rdata", d_rdata, exp_dr);
        chk("done_stall", stall, own_d ? pi : pd);
        if (own_d) pd = 0; else pi = 0;
        drive();
        tick();
        chk("idle_ack", {i_ack, d_ack}, 0);
    endtask

    initial begin
        logic got_d;
        do_reset();

        // single instruction read, minimum latency
        pi = 1; ia = 32'h0000_1004;
        do_txn(0, 0, 32'hDEAD_BEEF, got_d);
        chk("i_read_rdata", i_rdata, 32'hDEAD_BEEF);

        // halfword store at an unaligned address
        pd = 1; da = 32'h0000_2006; dwe = 4'b1100; dw = 32'hABCD_0000;
        do_txn(0, 1, $urandom, got_d);
        chk("store_acked_d", got_d, 1);

        // memory not ready for 5 cycles
        pd = 1; da = $urandom; dwe = 4'b0000; dw = $urandom;
        do_txn(5, 2, $urandom, got_d);

        // both ports hammering: D,D,D,D,I repeating
        do_reset();
        for (int t = 0; t < 10; t++) begin
            if (!pi) begin pi = 1; ia = $urandom; end
            if (!pd) begin pd = 1; da = $urandom; dwe = 4'($urandom); dw = $urandom; end
            do_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom, got_d);
            chk("grant_order", got_d, (t % 5 == 4) ? 1'b0 : 1'b1);
        end
        pi = 0; pd = 0; drive();
        tick();

        // stray responses while idle
        for (int t = 0; t < 3; t++) begin
            mem_resp_valid = 1; mem_resp_data = $urandom;
            tick();
            mem_resp_valid = 0;
            chk("stray_ack", {i_ack, d_ack}, 0);
            chk("stray_valid", mem_req_valid, 0);
            chk("stray_i_rdata", i_rdata, exp_ir);
            chk("stray_d_rdata", d_rdata, exp_dr);
        end

        // reset during WAIT, then a late response
        pd = 1; da = $urandom; dwe = 4'b0000; drive();
        tick();
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        #2 reset = 1;
        #1 chk_zero_outputs("midreset");
        pi = 0; pd = 0; drive();
        streak = 0; exp_ir = '0; exp_dr = '0;
        #2 reset = 0;
        mem_resp_valid = 1; mem_resp_data = $urandom;
        tick();
        mem_resp_valid = 0;
        chk("late_resp_ack", {i_ack, d_ack}, 0);
        chk("late_resp_valid", mem_req_valid, 0);
        chk("late_resp_d_rdata", d_rdata, 0);
        tick();
        chk("late_resp_ack2", {i_ack, d_ack}, 0);
        chk("late_resp_stall", stall, 0);

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            if (!pi && !pd && ($urandom % 4 == 0)) begin
                mem_resp_valid = 1; mem_resp_data = $urandom;
                tick();
                mem_resp_valid = 0;
                chk("rand_idle_ack", {i_ack, d_ack}, 0);
                chk("rand_idle_d_rdata", d_rdata, exp_dr);
            end
            if (!pi && ($urandom % 2 == 0)) begin pi = 1; ia = $urandom; end
            if (!pd && ($urandom % 2 == 0)) begin
                pd = 1; da = $urandom; dw = $urandom;
                dwe = ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom);
            end
            if (!pi && !pd) begin pi = 1; ia = $urandom; end
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, got_d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard bound on run time
    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_D_STREAK, default 4, max consecutive D-port grants while I-port waits (range 1..15).
REQ-002 Parameter: WIDTH, default 32, address/data width.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  instruction-read request, level, held until i_ack.
REQ-006 i_addr  input  WIDTH  instruction byte address.
REQ-007 i_ack  output  1  one-cycle pulse: I transaction complete, i_rdata valid.
REQ-008 i_rdata  output  WIDTH  instruction read data.
REQ-009 d_req  input  1  data request, level, held until d_ack.
REQ-010 d_we  input  4  byte write mask; 4'b0000 = read.
REQ-011 d_addr / d_wdata  input  WIDTH each  data byte address / write data.
REQ-012 d_ack  output  1  one-cycle pulse: D transaction complete, d_rdata valid.
REQ-013 d_rdata  output  WIDTH  data read data.
REQ-014 mem_req_valid  output  1  request to backing memory.
REQ-015 mem_req_ready  input  1  memory accepts request when high with mem_req_valid.
REQ-016 mem_rw / mem_wmask  output  1 / 4  1 = write / byte mask for writes.
REQ-017 mem_addr / mem_wdata  output  WIDTH each  word-aligned address / write data.
REQ-018 mem_resp_valid / mem_resp_data  input  1 / WIDTH  response strobe / read data.
REQ-019 stall  output  1  CPU pipeline hold.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, DONE; exactly one transaction outstanding.
REQ-021 IDLE: if any req high, pick owner, register request fields into mem_* registers, go ISSUE; else stay.
REQ-022 Priority: D over I, except I wins when both high and d_streak == MAX_D_STREAK.
REQ-023 d_streak: +1 on D grant with i_req high; cleared on I grant or on D grant with i_req low; saturates at MAX_D_STREAK.
REQ-024 ISSUE: mem_req_valid=1, fields stable; on mem_req_ready go WAIT; otherwise hold all fields.
REQ-025 WAIT: on mem_resp_valid capture mem_resp_data into owner's rdata register, go DONE.
REQ-026 DONE: owner's ack high exactly one cycle, then IDLE; no arbitration in DONE.
REQ-027 Writes also wait for mem_resp_valid; response data on writes is discarded and d_rdata holds its previous value.
REQ-028 mem_addr = {addr[WIDTH-1:2], 2'b00}; mem_wmask = d_we; mem_rw = |d_we; I requests always mem_rw=0, mask 0.
REQ-029 mem_resp_valid outside WAIT is ignored; memory never responds in the acceptance cycle.
REQ-030 Requester keeping req high in the cycle after ack issues a new request (back-to-back allowed).
REQ-031 Minimum latency: req in IDLE at cycle N, ready at N+1, resp at N+2 -> ack at N+3.
REQ-032 stall = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
REQ-033 Request inputs are sampled only in IDLE; changes during ISSUE/WAIT/DONE have no effect.

Reset
REQ-034 Reset asserted forces IDLE immediately; all outputs 0, d_streak 0, rdata registers 0.
REQ-035 Reset mid-transaction abandons it; no ack issued; late mem_resp_valid after reset ignored.

Verification
REQ-036 Single I read 0x0000_1004, ready immediate, resp data 0xDEAD_BEEF next cycle -> mem_addr 0x0000_1004, i_ack at cycle N+3, i_rdata 0xDEAD_BEEF.
REQ-037 D store sh d_addr 0x0000_2006, d_we 4'b1100, d_wdata 0xABCD_0000 -> mem_addr 0x0000_2004, mem_rw 1, mem_wmask 4'b1100, d_ack after resp.
REQ-038 i_req and d_req both held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-039 mem_req_ready low 5 cycles in ISSUE -> mem_req_valid and fields stable all 5 cycles, stall stays 1.
REQ-040 Reset pulse during WAIT then mem_resp_valid -> no ack, state IDLE, all outputs 0.
REQ-041 mem_resp_valid pulsed in IDLE with no request -> no ack, rdata unchanged.
